// File: rtl/rr_logb_gearbox.sv
// Variable-length to fixed-width gearbox: packs logb records bit-densely into
// OUT_WIDTH beats, with an explicit flush that emits a zero-padded final beat.
module rr_logb_gearbox #(
  parameter int IN_WIDTH  = 1024,
  parameter int OUT_WIDTH = 512,
  localparam int LEN_WIDTH = $clog2(IN_WIDTH + 1),
  localparam int CNT_WIDTH = $clog2(IN_WIDTH + OUT_WIDTH),
  localparam int BUF_WIDTH = IN_WIDTH + OUT_WIDTH - 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [LEN_WIDTH-1:0] in_len,
  output logic                 in_ready,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 flush_done,
  output logic [CNT_WIDTH-1:0] fill_bits,
  output logic [31:0]          beat_count
);

  if (OUT_WIDTH < 1) begin : g_bad_out_width
    $error("rr_logb_gearbox: OUT_WIDTH must be at least 1");
  end

  typedef enum logic {RUN, DRAIN} state_t;

  localparam logic [CNT_WIDTH-1:0] OUT_CNT  = CNT_WIDTH'(OUT_WIDTH);
  localparam logic [OUT_WIDTH-1:0] OUT_ONES = '1;
  localparam logic [IN_WIDTH-1:0]  IN_ONES  = '1;

  state_t               state, state_next;
  logic [BUF_WIDTH-1:0] acc, acc_next, acc_shift, in_ext;
  logic [CNT_WIDTH-1:0] cnt, cnt_next, base;
  logic [OUT_WIDTH-1:0] out_mask;
  logic                 full_beat, pop, push, flush_done_next;

  assign fill_bits = cnt;

  always_comb begin
    full_beat = (cnt >= OUT_CNT);
    out_valid = full_beat || (state == DRAIN && cnt != '0);
    out_last  = out_valid && !full_beat;
    out_mask  = full_beat ? OUT_ONES : ~(OUT_ONES << cnt);
    out_data  = acc[OUT_WIDTH-1:0] & out_mask;
    pop       = out_valid && out_ready;

    // A partial beat can only be the final flush beat, so it empties the buffer.
    base      = cnt;
    acc_shift = acc;
    if (pop) begin
      base      = full_beat ? cnt - OUT_CNT : '0;
      acc_shift = full_beat ? acc >> OUT_WIDTH : '0;
    end

    in_ready = (state == RUN) && (base < OUT_CNT);
    push     = in_valid && in_ready;

    in_ext = '0;
    in_ext[IN_WIDTH-1:0] = in_data & ~(IN_ONES << in_len);

    acc_next = push ? (acc_shift | (in_ext << base)) : acc_shift;
    cnt_next = base + (push ? CNT_WIDTH'(in_len) : '0);
  end

  always_comb begin
    state_next      = state;
    flush_done_next = 1'b0;
    unique case (state)
      RUN: begin
        if (flush) state_next = DRAIN;
      end
      DRAIN: begin
        if (cnt_next == '0) begin
          state_next      = RUN;
          flush_done_next = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      acc        <= '0;
      cnt        <= '0;
      flush_done <= 1'b0;
      beat_count <= '0;
    end else begin
      state      <= state_next;
      acc        <= acc_next;
      cnt        <= cnt_next;
      flush_done <= flush_done_next;
      if (pop) beat_count <= beat_count + 32'd1;
      if (in_valid)
        assert (in_len <= LEN_WIDTH'(IN_WIDTH))
          else $error("rr_logb_gearbox: in_len %0d exceeds IN_WIDTH", in_len);
    end
  end

endmodule

// File: tb/tb_rr_logb_gearbox.sv
// Bench for rr_logb_gearbox (IN_WIDTH=48, OUT_WIDTH=32): directed scenarios plus
// random traffic, checked against a bit-queue reference model.
module tb_rr_logb_gearbox;

  localparam int IW = 48;
  localparam int OW = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [47:0] in_data = '0;
  logic [5:0]  in_len = '0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic        flush_done;
  logic [6:0]  fill_bits;
  logic [31:0] beat_count;

  rr_logb_gearbox #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_len(in_len),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .flush_done(flush_done),
    .fill_bits(fill_bits), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the stream of buffered bits, oldest first.
  bit          mq[$];
  bit          m_drain = 1'b0;
  bit          m_fd = 1'b0;
  int unsigned m_beats = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_drain = 1'b0;
    m_fd    = 1'b0;
    m_beats = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_len = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive inputs, compare every output to the model, then advance.
  task automatic step(input logic iv, input logic [47:0] d, input int len,
                      input logic ordy, input logic fl);
    int unsigned sz, take, base;
    logic        eov, eir, elast;
    logic [31:0] ed;
    in_valid = iv; in_data = d; in_len = 6'(len); out_ready = ordy; flush = fl;
    #1;
    sz    = mq.size();
    eov   = (sz >= OW) || (m_drain && sz > 0);
    elast = eov && (sz < OW);
    take  = (eov && ordy) ? ((sz >= OW) ? OW : sz) : 0;
    base  = sz - take;
    eir   = !m_drain && (base < OW);
    for (int i = 0; i < OW; i++) ed[i] = (i < sz) ? mq[i] : 1'b0;
    check("out_valid", 64'(out_valid), 64'(eov));
    check("in_ready", 64'(in_ready), 64'(eir));
    check("out_last", 64'(out_last), 64'(elast));
    check("fill_bits", 64'(fill_bits), 64'(sz));
    check("beat_count", 64'(beat_count), 64'(m_beats));
    check("flush_done", 64'(flush_done), 64'(m_fd));
    if (eov) check("out_data", 64'(out_data), 64'(ed));
    @(posedge clk); #1;
    for (int i = 0; i < int'(take); i++) mq.delete(0);
    if (iv && eir) for (int i = 0; i < len; i++) mq.push_back(d[i]);
    if (take > 0) m_beats++;
    m_fd = 1'b0;
    if (!m_drain) begin
      if (fl) m_drain = 1'b1;
    end else if (mq.size() == 0) begin
      m_drain = 1'b0;
      m_fd    = 1'b1;
    end
  endtask

  initial begin
    do_reset();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_fill", 64'(fill_bits), 64'd0);
    step(0, '0, 0, 1, 0);

    // Small records
    step(1, 48'hAAAA, 16, 1, 0);
    step(1, 48'hBBBB, 16, 1, 0);
    check("small_valid", 64'(out_valid), 64'd1);
    check("small_data", 64'(out_data), 64'hBBBBAAAA);
    step(1, 48'hCCCC, 16, 1, 0);
    check("small_fill", 64'(fill_bits), 64'd16);
    check("small_beats", 64'(beat_count), 64'd1);

    // Flush with residue
    step(0, '0, 0, 1, 1);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    check("flush_last", 64'(out_last), 64'd1);
    check("flush_data", 64'(out_data), 64'h0000CCCC);
    step(0, '0, 0, 1, 0);
    check("flush_done_pulse", 64'(flush_done), 64'd1);
    check("flush_ready_back", 64'(in_ready), 64'd1);
    step(0, '0, 0, 1, 0);
    check("flush_done_gone", 64'(flush_done), 64'd0);

    // Full rate
    for (int k = 1; k <= 6; k++) begin
      step(1, {16'($urandom), 32'(k)}, 32, 1, 0);
      check("full_rate_data", 64'(out_data), 64'(k));
    end
    step(0, '0, 0, 1, 0);

    // Backpressure
    step(1, 48'hFFFF_12345678, 48, 0, 0);
    check("bp_data", 64'(out_data), 64'h12345678);
    step(0, '0, 0, 0, 0);
    check("bp_hold", 64'(out_data), 64'h12345678);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    step(1, 48'h5555, 16, 1, 0);
    check("bp_fill", 64'(fill_bits), 64'd32);
    check("bp_next_data", 64'(out_data), 64'h5555FFFF);
    step(0, '0, 0, 1, 1);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);

    // Empty flush and zero-length record
    step(0, '0, 0, 1, 1);
    step(0, '0, 0, 1, 0);
    check("empty_flush_done", 64'(flush_done), 64'd1);
    step(1, 48'h1234, 16, 1, 0);
    step(1, {16'($urandom), 32'($urandom)}, 0, 1, 0);
    check("zero_len_fill", 64'(fill_bits), 64'd16);
    step(0, '0, 0, 1, 1);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);

    // Random traffic
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 3) != 0, {16'($urandom), 32'($urandom)},
           int'($urandom_range(0, IW)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0);

    // Reset mid-operation during DRAIN
    do_reset();
    step(1, {16'($urandom), 32'($urandom)}, 48, 0, 0);
    step(0, '0, 0, 0, 1);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    do_reset();
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_last", 64'(out_last), 64'd0);
    check("mid_rst_fill", 64'(fill_bits), 64'd0);
    check("mid_rst_beats", 64'(beat_count), 64'd0);
    check("mid_rst_fd", 64'(flush_done), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
